// File: rtl/sync_fifo_ctrl_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl_param
//
// Single-clock FIFO combining write control, read control and the storage
// array. Keeps a registered fill level, derives status and programmable
// threshold flags from it, records sticky overflow/underflow errors, supports
// a synchronous flush, and offers registered or first-word-fall-through reads.
//
// Parameters
//   ADDR_WIDTH  address bits; DEPTH = 2**ADDR_WIDTH entries (>= 2)
//   DATA_WIDTH  stored word width
//   FWFT        0: r_data registered on an accepted pop (valid with read_ack)
//               1: r_data shows the head word combinationally (0 when empty)
//
// Ports
//   clk_logic              clock, all state on the rising edge
//   reset                  asynchronous active-high reset
//   flush                  synchronous clear of pointers and level
//   write_request, w_data  push request and data
//   write_ack              one-cycle pulse after an accepted push
//   read_request           pop request
//   r_data                 read data (see FWFT)
//   read_ack               one-cycle pulse after an accepted pop
//   af_threshold           almost_full when level >= this value
//   ae_threshold           almost_empty when level <= this value
//   clear_err              clears the sticky error flags
//   fifo_level             stored word count, 0..DEPTH
//   write_pointer          write pointer with wrap bit as MSB
//   read_pointer           read pointer with wrap bit as MSB
//   full/halffull/empty/halfempty_fifo_status  level-derived status flags
//   almost_full, almost_empty                  threshold flags
//   overflow_err, underflow_err                sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_ctrl_param #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk_logic,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write_request,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  write_ack,
  input  logic                  read_request,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  read_ack,
  input  logic [ADDR_WIDTH:0]   af_threshold,
  input  logic [ADDR_WIDTH:0]   ae_threshold,
  input  logic                  clear_err,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic [ADDR_WIDTH:0]   write_pointer,
  output logic [ADDR_WIDTH:0]   read_pointer,
  output logic                  full_fifo_status,
  output logic                  halffull_fifo_status,
  output logic                  empty_fifo_status,
  output logic                  halfempty_fifo_status,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned HALF  = DEPTH / 2;

  // Level constants sized to the pointer/level width (DEPTH fits in ADDR_WIDTH+1 bits).
  localparam logic [ADDR_WIDTH:0] LvlFull = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LvlHalf = HALF[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LvlZero = '0;
  localparam logic [ADDR_WIDTH:0] CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_wack;
  logic                  r_rack;
  logic                  r_ovf;
  logic                  r_unf;

  // ---------------------------------------------------------------------------
  // Combinational status and acceptance
  // ---------------------------------------------------------------------------
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [DATA_WIDTH-1:0] w_head;
  logic [ADDR_WIDTH:0]   w_wptr_d;
  logic [ADDR_WIDTH:0]   w_rptr_d;
  logic [ADDR_WIDTH:0]   w_level_d;
  logic                  w_ovf_d;
  logic                  w_unf_d;

  assign w_full  = (r_level == LvlFull);
  assign w_empty = (r_level == LvlZero);

  // Full-and-both-requested naturally pops and rejects the push; empty-and-both
  // pushes and rejects the pop, since each side only looks at its own flag.
  assign w_push_ok = write_request & ~w_full  & ~flush;
  assign w_pop_ok  = read_request  & ~w_empty & ~flush;

  assign w_ovf_set = write_request & w_full  & ~flush;
  assign w_unf_set = read_request  & w_empty & ~flush;

  assign w_waddr = r_wptr[ADDR_WIDTH-1:0];
  assign w_raddr = r_rptr[ADDR_WIDTH-1:0];
  assign w_head  = r_mem[w_raddr];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wptr_d  = r_wptr;
    w_rptr_d  = r_rptr;
    w_level_d = r_level;

    if (flush) begin
      w_wptr_d  = '0;
      w_rptr_d  = '0;
      w_level_d = '0;
    end else begin
      if (w_push_ok) w_wptr_d = r_wptr + CntOne;
      if (w_pop_ok)  w_rptr_d = r_rptr + CntOne;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   w_level_d = r_level + CntOne;
        2'b01:   w_level_d = r_level - CntOne;
        default: w_level_d = r_level;
      endcase
    end
  end

  // Set beats clear when both happen in one cycle.
  always_comb begin
    w_ovf_d = r_ovf;
    w_unf_d = r_unf;
    if (clear_err) begin
      w_ovf_d = 1'b0;
      w_unf_d = 1'b0;
    end
    if (w_ovf_set) w_ovf_d = 1'b1;
    if (w_unf_set) w_unf_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_logic or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_wack  <= 1'b0;
      r_rack  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_d;
      r_rptr  <= w_rptr_d;
      r_level <= w_level_d;
      r_wack  <= w_push_ok;
      r_rack  <= w_pop_ok;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_logic) begin
    if (w_push_ok) begin
      r_mem[w_waddr] <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  if (FWFT != 0) begin : g_fwft
    assign r_data = w_empty ? '0 : w_head;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk_logic or posedge reset) begin
      if (reset) begin
        r_rdata <= '0;
      end else if (w_pop_ok) begin
        r_rdata <= w_head;
      end
    end

    assign r_data = r_rdata;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign write_ack     = r_wack;
  assign read_ack      = r_rack;
  assign fifo_level    = r_level;
  assign write_pointer = r_wptr;
  assign read_pointer  = r_rptr;

  assign full_fifo_status      = w_full;
  assign empty_fifo_status     = w_empty;
  assign halffull_fifo_status  = (r_level >= LvlHalf);
  assign halfempty_fifo_status = (r_level <= LvlHalf);
  assign almost_full           = (r_level >= af_threshold);
  assign almost_empty          = (r_level <= ae_threshold);

  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: tb/tb_sync_fifo_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctrl_param
//
// Drives a registered-read instance (u_dut0) and an FWFT instance (u_dut1)
// with the same stimulus. A reference model tracks level, pointers, errors and
// a queue of stored words; expected read data is popped from that queue on
// every accepted pop. A table covers fill-to-overflow and drain-to-underflow;
// hand-written sequences cover reset, wrap, simultaneous traffic, FWFT, flush.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctrl_param;

  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk_logic = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          write_request = 1'b0;
  logic          read_request = 1'b0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [AW:0]   af_threshold = 4'd6;
  logic [AW:0]   ae_threshold = 4'd2;

  logic [DW-1:0] r_data0, r_data1;
  logic          wack0, rack0, full0, hf0, empty0, he0, af0, ae0, ovf0, unf0;
  logic          wack1, rack1, full1, hf1, empty1, he1, af1, ae1, ovf1, unf1;
  logic [AW:0]   level0, wptr0, rptr0, level1, wptr1, rptr1;
  logic [9:0]    st0, st1;

  assign st0 = {full0, hf0, empty0, he0, af0, ae0, ovf0, unf0, wack0, rack0};
  assign st1 = {full1, hf1, empty1, he1, af1, ae1, ovf1, unf1, wack1, rack1};

  sync_fifo_ctrl_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_dut0 (
    .clk_logic(clk_logic), .reset(reset), .flush(flush),
    .write_request(write_request), .w_data(w_data), .write_ack(wack0),
    .read_request(read_request), .r_data(r_data0), .read_ack(rack0),
    .af_threshold(af_threshold), .ae_threshold(ae_threshold), .clear_err(clear_err),
    .fifo_level(level0), .write_pointer(wptr0), .read_pointer(rptr0),
    .full_fifo_status(full0), .halffull_fifo_status(hf0), .empty_fifo_status(empty0),
    .halfempty_fifo_status(he0), .almost_full(af0), .almost_empty(ae0),
    .overflow_err(ovf0), .underflow_err(unf0)
  );

  sync_fifo_ctrl_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_dut1 (
    .clk_logic(clk_logic), .reset(reset), .flush(flush),
    .write_request(write_request), .w_data(w_data), .write_ack(wack1),
    .read_request(read_request), .r_data(r_data1), .read_ack(rack1),
    .af_threshold(af_threshold), .ae_threshold(ae_threshold), .clear_err(clear_err),
    .fifo_level(level1), .write_pointer(wptr1), .read_pointer(rptr1),
    .full_fifo_status(full1), .halffull_fifo_status(hf1), .empty_fifo_status(empty1),
    .halfempty_fifo_status(he1), .almost_full(af1), .almost_empty(ae1),
    .overflow_err(ovf1), .underflow_err(unf1)
  );

  initial forever #5 clk_logic = ~clk_logic;

  // ---------------------------------------------------------------------------
  // Checking and reference model
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  int            m_level = 0;
  int            m_wptr = 0;
  int            m_rptr = 0;
  bit            m_ovf = 0, m_unf = 0, m_wack = 0, m_rack = 0;
  logic [DW-1:0] m_rd0 = '0;
  logic [DW-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] exp_status();
    return {m_level == DEPTH, m_level >= DEPTH / 2, m_level == 0, m_level <= DEPTH / 2,
            m_level >= int'(af_threshold), m_level <= int'(ae_threshold),
            m_ovf, m_unf, m_wack, m_rack};
  endfunction

  task automatic check_all(input string tag);
    logic [DW-1:0] head;
    head = (m_level == 0) ? '0 : sb[0];
    chk({tag, " level0"}, 32'(level0), 32'(m_level));
    chk({tag, " wptr0"}, 32'(wptr0), 32'(m_wptr));
    chk({tag, " rptr0"}, 32'(rptr0), 32'(m_rptr));
    chk({tag, " status0"}, 32'(st0), 32'(exp_status()));
    chk({tag, " rdata0"}, 32'(r_data0), 32'(m_rd0));
    chk({tag, " level1"}, 32'(level1), 32'(m_level));
    chk({tag, " ptrs1"}, {24'(wptr1), 8'(rptr1)}, {24'(m_wptr), 8'(m_rptr)});
    chk({tag, " status1"}, 32'(st1), 32'(exp_status()));
    chk({tag, " rdata1"}, 32'(r_data1), 32'(head));
  endtask

  task automatic model_reset();
    m_level = 0; m_wptr = 0; m_rptr = 0;
    m_ovf = 0; m_unf = 0; m_wack = 0; m_rack = 0;
    m_rd0 = '0;
    sb.delete();
  endtask

  // Called just after an active edge; drives inputs, advances one edge, checks.
  task automatic step(input string tag, input bit wr, input bit rd, input logic [DW-1:0] wd,
                      input bit fl, input bit ce);
    bit push, pop, oset, uset;
    push = wr && (m_level != DEPTH) && !fl;
    pop  = rd && (m_level != 0) && !fl;
    oset = wr && (m_level == DEPTH) && !fl;
    uset = rd && (m_level == 0) && !fl;
    write_request = wr; read_request = rd; w_data = wd; flush = fl; clear_err = ce;
    @(posedge clk_logic);
    if (pop)  m_rd0 = sb.pop_front();
    if (push) sb.push_back(wd);
    if (fl) begin
      sb.delete();
      m_level = 0; m_wptr = 0; m_rptr = 0;
    end else begin
      m_level = m_level + int'(push) - int'(pop);
      m_wptr  = (m_wptr + int'(push)) % (2 * DEPTH);
      m_rptr  = (m_rptr + int'(pop)) % (2 * DEPTH);
    end
    m_ovf  = oset ? 1'b1 : (ce ? 1'b0 : m_ovf);
    m_unf  = uset ? 1'b1 : (ce ? 1'b0 : m_unf);
    m_wack = push;
    m_rack = pop;
    #1;
    check_all(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: fill past full, then drain past empty
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            wr;
    bit            rd;
    logic [DW-1:0] wd;
    int            lvl;
    bit            wack;
    bit            rack;
    logic [DW-1:0] rdat;
    bit            ovf;
    bit            unf;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int wa_cnt, ra_cnt;

    for (int i = 0; i < 9; i++) begin
      tbl[i] = '{wr: 1'b1, rd: 1'b0, wd: 16'h1000 + 16'(i), lvl: (i < 8) ? i + 1 : 8,
                 wack: (i < 8), rack: 1'b0, rdat: 16'h0000, ovf: (i == 8), unf: 1'b0};
    end
    for (int j = 0; j < 9; j++) begin
      tbl[9 + j] = '{wr: 1'b0, rd: 1'b1, wd: 16'h0000, lvl: (j < 8) ? 7 - j : 0,
                     wack: 1'b0, rack: (j < 8), rdat: (j < 8) ? 16'h1000 + 16'(j) : 16'h1007,
                     ovf: 1'b1, unf: (j == 8)};
    end

    // Reset state, then release between edges
    #2;
    check_all("reset");
    @(posedge clk_logic); #1;
    reset = 1'b0;

    for (int k = 0; k < 18; k++) begin
      step($sformatf("tbl%0d", k), tbl[k].wr, tbl[k].rd, tbl[k].wd, 1'b0, 1'b0);
      chk($sformatf("tbl%0d lvl", k), 32'(level0), 32'(tbl[k].lvl));
      chk($sformatf("tbl%0d acks", k), {30'd0, wack0, rack0}, {30'd0, tbl[k].wack, tbl[k].rack});
      chk($sformatf("tbl%0d errs", k), {30'd0, ovf0, unf0}, {30'd0, tbl[k].ovf, tbl[k].unf});
      if (tbl[k].rack) chk($sformatf("tbl%0d rdata", k), 32'(r_data0), 32'(tbl[k].rdat));
    end

    // Clear errors, set underflow again, then reset mid-operation between edges
    step("clr", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("clr errs", {30'd0, ovf0, unf0}, 32'd0);
    step("unf", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    step("pre_rst_w0", 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b0);
    step("pre_rst_w1", 1'b1, 1'b0, 16'hAAAB, 1'b0, 1'b0);
    step("pre_rst_r", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst unf", 32'(unf0), 32'd0);
    @(posedge clk_logic); #1;
    reset = 1'b0;

    // Wrap-around: 5 writes, 5 reads, 6 writes, then read back across the wrap
    for (int i = 0; i < 5; i++) step("wrap_w", 1'b1, 1'b0, 16'h2000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("wrap_r", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("wrap_w2", 1'b1, 1'b0, 16'h3000 + 16'(i), 1'b0, 1'b0);
    chk("wrap wptr", 32'(wptr0), 32'd11);
    chk("wrap level", 32'(level0), 32'd6);
    for (int i = 0; i < 6; i++) begin
      step("wrap_r2", 1'b0, 1'b1, '0, 1'b0, 1'b0);
      chk("wrap rdata", 32'(r_data0), 32'(16'h3000 + 16'(i)));
    end

    // Simultaneous push and pop at level 4
    for (int i = 0; i < 4; i++) step("sim_fill", 1'b1, 1'b0, 16'h4000 + 16'(i), 1'b0, 1'b0);
    wa_cnt = 0; ra_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step("sim_rw", 1'b1, 1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
      wa_cnt += int'(wack0);
      ra_cnt += int'(rack0);
    end
    chk("sim wacks", 32'(wa_cnt), 32'd10);
    chk("sim racks", 32'(ra_cnt), 32'd10);
    chk("sim level", 32'(level0), 32'd4);
    for (int i = 0; i < 4; i++) step("sim_top", 1'b1, 1'b0, 16'h6000 + 16'(i), 1'b0, 1'b0);
    chk("full", 32'(full0), 32'd1);
    step("full_rw", 1'b1, 1'b1, 16'h6FFF, 1'b0, 1'b0);
    chk("full_rw ovf", 32'(ovf0), 32'd1);
    chk("full_rw acks", {30'd0, wack0, rack0}, 32'd1);
    chk("full_rw level", 32'(level0), 32'd7);
    for (int i = 0; i < 7; i++) step("drain", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    step("clr2", 1'b0, 1'b0, '0, 1'b0, 1'b1);

    // FWFT head visibility
    chk("fwft empty rdata", 32'(r_data1), 32'd0);
    step("fwft_w", 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    chk("fwft head", 32'(r_data1), 32'h0000BEEF);
    chk("fwft not empty", 32'(empty1), 32'd0);
    step("fwft_r", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    chk("fwft rack", 32'(rack1), 32'd1);
    chk("fwft after pop", 32'(r_data1), 32'd0);
    chk("fwft empty", 32'(empty1), 32'd1);
    chk("reg rdata", 32'(r_data0), 32'h0000BEEF);
    step("idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Flush at level 5 with a concurrent write; errors retained
    step("fl_unf", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("fl_w", 1'b1, 1'b0, 16'h7000 + 16'(i), 1'b0, 1'b0);
    step("flush", 1'b1, 1'b0, 16'h7777, 1'b1, 1'b0);
    chk("flush level", 32'(level0), 32'd0);
    chk("flush wack", 32'(wack0), 32'd0);
    chk("flush unf kept", 32'(unf0), 32'd1);
    chk("flush rdata kept", 32'(r_data0), 32'h0000BEEF);
    step("idle2", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    step("clr3", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("clr3 unf", 32'(unf0), 32'd0);
    step("post_fl_w", 1'b1, 1'b0, 16'h8888, 1'b0, 1'b0);
    step("post_fl_r", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    chk("post flush rdata", 32'(r_data0), 32'h00008888);
    step("idle3", 1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
